// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional rsp_zero output enabled by defining ALU_RR_ZERO_FLAG_EN.
module alu_rr_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
`ifdef ALU_RR_ZERO_FLAG_EN
  ,
  output logic             rsp_zero
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
  } req_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_nxt;
  req_t  [1:0] req;
  logic  [1:0] grant;
  logic        gsel;
  logic        ptr;
  logic        owner;

  assign req[0] = {req0_a, req0_b, req0_op};
  assign req[1] = {req1_a, req1_b, req1_op};

  // Grant is only ever raised in IDLE; the pointer breaks ties only.
  always_comb begin
    state_nxt = state;
    grant     = 2'b00;
    case (state)
      IDLE: begin
        case (req_valid)
          2'b01:   grant = 2'b01;
          2'b10:   grant = 2'b10;
          2'b11:   grant = ptr ? 2'b10 : 2'b01;
          default: grant = 2'b00;
        endcase
        if (|grant) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready[owner]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign gsel      = grant[1];
  assign req_ready = grant;
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= 2'b00;
      rsp_data <= '0;
      owner    <= 1'b0;
      ptr      <= 1'b0;
    end else begin
      // Operands are held after the operation so the ALU inputs stay quiet in IDLE.
      if (state == IDLE && |grant) begin
        alu_a   <= req[gsel].a;
        alu_b   <= req[gsel].b;
        alu_sel <= req[gsel].op;
        owner   <= gsel;
      end
      if (state == EXEC) rsp_data <= alu_result;
      if (state == RESP && rsp_ready[owner]) ptr <= ~owner;
    end
  end

`ifdef ALU_RR_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             rsp_zero <= 1'b0;
    else if (state == EXEC) rsp_zero <= (alu_result == '0);
  end
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a behavioural ALU model attached.
module tb_alu_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_op, req1_op;
  logic [15:0] alu_a, alu_b, alu_result, rsp_data;
  logic [1:0]  alu_sel, rsp_valid, rsp_ready;
  logic        busy;
`ifdef ALU_RR_ZERO_FLAG_EN
  logic        rsp_zero;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  alu_rr_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .busy(busy)
`ifdef ALU_RR_ZERO_FLAG_EN
    , .rsp_zero(rsp_zero)
`endif
  );

  // Shared ALU: add, sub, and, or; carry discarded.
  always_comb begin
    case (alu_sel)
      2'b00:   alu_result = alu_a + alu_b;
      2'b01:   alu_result = alu_a - alu_b;
      2'b10:   alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation from IDLE with rsp_ready high; req_valid is left as given.
  task automatic run_op(input string tag, input logic [1:0] vld, input logic [1:0] g,
                        input logic [15:0] d);
    req_valid = vld;
    rsp_ready = 2'b11;
    #1;
    chk({tag, "_grant"}, req_ready, g);
    tick;
    chk({tag, "_exec_busy"}, busy, 1'b1);
    chk({tag, "_exec_rspv"}, rsp_valid, 2'b00);
    tick;
    chk({tag, "_rspv"}, rsp_valid, g);
    chk({tag, "_data"}, rsp_data, d);
`ifdef ALU_RR_ZERO_FLAG_EN
    chk({tag, "_zero"}, rsp_zero, (d == 16'h0000));
`endif
    tick;
    chk({tag, "_done_rspv"}, rsp_valid, 2'b00);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req0_a = '0; req0_b = '0; req0_op = 2'b00;
    req1_a = '0; req1_b = '0; req1_op = 2'b00;
    #12;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_data", rsp_data, 16'h0000);
    chk("rst_alu", {alu_a, alu_b}, 32'h0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick;

    // Single requester, response held one extra cycle so busy spans 3 cycles.
    req0_a = 16'h0005; req0_b = 16'h0003; req0_op = 2'b00; req_valid = 2'b01;
    #1;
    chk("t1_grant", req_ready, 2'b01);
    chk("t1_idle_busy", busy, 1'b0);
    tick;
    req_valid = 2'b00;
    chk("t1_exec_busy", busy, 1'b1);
    chk("t1_exec_ready", req_ready, 2'b00);
    chk("t1_exec_alu_a", alu_a, 16'h0005);
    chk("t1_exec_rspv", rsp_valid, 2'b00);
    tick;
    chk("t1_rspv", rsp_valid, 2'b01);
    chk("t1_data", rsp_data, 16'h0008);
    chk("t1_resp_busy", busy, 1'b1);
    tick;
    chk("t1_hold_rspv", rsp_valid, 2'b01);
    chk("t1_hold_busy", busy, 1'b1);
    rsp_ready = 2'b01;
    tick;
    chk("t1_done_rspv", rsp_valid, 2'b00);
    chk("t1_done_busy", busy, 1'b0);
    chk("t1_alu_kept", alu_a, 16'h0005);

    // Reset pulse away from any edge puts the pointer back to 0.
    rst_n = 1'b0; rsp_ready = 2'b00;
    #1;
    rst_n = 1'b1;

    // Both valid with pointer 0: req0 first, then req1.
    req0_a = 16'h0003; req0_b = 16'h0005; req0_op = 2'b01;
    req1_a = 16'hF0F0; req1_b = 16'h0FF0; req1_op = 2'b10;
    req_valid = 2'b11;
    #1;
    chk("t2_grant0", req_ready, 2'b01);
    tick;
    req_valid = 2'b10;
    chk("t2_exec_sel", alu_sel, 2'b01);
    tick;
    chk("t2_rspv0", rsp_valid, 2'b01);
    chk("t2_data0", rsp_data, 16'hFFFE);
    chk("t2_resp_noaccept", req_ready, 2'b00);
    rsp_ready = 2'b10;
    tick;
    chk("t2_nonowner_ignored", rsp_valid, 2'b01);
    rsp_ready = 2'b01;
    tick;
    chk("t2_grant1", req_ready, 2'b10);
    tick;
    req_valid = 2'b00;
    tick;
    chk("t2_rspv1", rsp_valid, 2'b10);
    chk("t2_data1", rsp_data, 16'h00F0);
    rsp_ready = 2'b10;
    tick;
    chk("t2_done", rsp_valid, 2'b00);

    // Continuous requests from both sides alternate 0,1,0,1.
    req0_a = 16'h0010; req0_b = 16'h0001; req0_op = 2'b00;
    req1_a = 16'h0100; req1_b = 16'h0001; req1_op = 2'b01;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) run_op("t3_rr0", 2'b11, 2'b01, 16'h0011);
      else            run_op("t3_rr1", 2'b11, 2'b10, 16'h00FF);
    end

    // Stalled response: outputs stay put and nothing new is accepted.
    req0_a = 16'h00F0; req0_b = 16'h000F; req0_op = 2'b11;
    req_valid = 2'b01; rsp_ready = 2'b00;
    #1;
    chk("t4_grant", req_ready, 2'b01);
    tick;
    req_valid = 2'b10;
    req1_a = 16'h1234; req1_b = 16'h0000; req1_op = 2'b11;
    tick;
    for (int i = 0; i < 10; i++) begin
      chk("t4_stall_rspv", rsp_valid, 2'b01);
      chk("t4_stall_data", rsp_data, 16'h00FF);
      chk("t4_stall_ready", req_ready, 2'b00);
      if (i == 4) rsp_ready = 2'b10;
      tick;
    end
    rsp_ready = 2'b01;
    tick;
    chk("t4_release_rspv", rsp_valid, 2'b00);
    chk("t4_release_grant", req_ready, 2'b10);
    run_op("t4_req1", 2'b10, 2'b10, 16'h1234);

    // Reset during EXEC drops the operation and the pointer.
    req0_a = 16'h0005; req0_b = 16'h0003; req0_op = 2'b00;
    req1_a = 16'h0100; req1_b = 16'h0001; req1_op = 2'b01;
    run_op("t5_pre", 2'b01, 2'b01, 16'h0008);
    tick;
    req_valid = 2'b00;
    chk("t5_exec_alu_a", alu_a, 16'h0005);
    chk("t5_exec_busy", busy, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_rspv", rsp_valid, 2'b00);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_alu", {alu_a, alu_b}, 32'h0);
    chk("t5_rst_sel", alu_sel, 2'b00);
    chk("t5_rst_ready", req_ready, 2'b00);
    #1;
    rst_n = 1'b1;
    run_op("t5_post", 2'b11, 2'b01, 16'h0008);

    // Zero results, including add wrap-around.
    req0_a = 16'h1234; req0_b = 16'h1234; req0_op = 2'b01;
    run_op("t6_sub0", 2'b01, 2'b01, 16'h0000);
    req0_a = 16'hFFFF; req0_b = 16'h0001; req0_op = 2'b00;
    run_op("t6_wrap", 2'b01, 2'b01, 16'h0000);
    req_valid = 2'b00;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
